// File: rtl/sgd_model_writeback.sv
// sgd_model_writeback: takes the SGD engine's model write-back stream and
// turns it into memory write bursts. Model words are buffered in a FIFO, and
// bursts are split at the maximum burst size and at 4 KB page boundaries.
module sgd_model_writeback #(
  parameter int DATA_W     = 512,
  parameter int ADDR_W     = 64,
  parameter int FIFO_DEPTH = 64,
  parameter int AF_MARGIN  = 8,
  parameter int MAX_BURST  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              x_data_send_back_start,
  input  logic [ADDR_W-1:0] x_data_send_back_addr,
  input  logic [31:0]       x_data_send_back_length,
  input  logic [DATA_W-1:0] x_data_out,
  input  logic              x_data_out_valid,
  output logic              x_data_out_almost_full,
  output logic              wr_cmd_valid,
  input  logic              wr_cmd_ready,
  output logic [ADDR_W-1:0] wr_cmd_addr,
  output logic [7:0]        wr_cmd_len,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_data_valid,
  input  logic              wr_data_ready,
  output logic              wr_data_last,
  output logic              busy,
  output logic              done,
  output logic              err_overflow,
  output logic              err_start_busy
);

  // Bytes per beat is a power of two, so byte counts become beat counts by a shift
  localparam int BEAT_SHIFT = $clog2(DATA_W / 8);
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = PTR_W + 1;
  localparam int BURST_W    = $clog2(MAX_BURST) + 1;
  localparam int REM_W      = 32 - BEAT_SHIFT;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_CMD,
    S_DATA,
    S_DONE
  } state_t;

  state_t r_state;

  logic [DATA_W-1:0]  r_fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wrPtr;
  logic [PTR_W-1:0]   r_rdPtr;
  logic [CNT_W-1:0]   r_count;
  logic               r_almostFull;
  logic               r_errOverflow;
  logic               r_errStartBusy;

  logic [ADDR_W-1:0]  r_curAddr;
  logic [REM_W-1:0]   r_remBeats;
  logic [BURST_W-1:0] r_burstBeats;
  logic [BURST_W-1:0] r_beatCnt;

  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_dataValid;
  logic               w_cmdValid;
  logic [12:0]        w_boundaryBytes;
  logic [12:0]        w_boundaryBeats;
  logic [REM_W-1:0]   w_capRem;
  logic [REM_W-1:0]   w_capPage;
  logic [REM_W-1:0]   w_burstCalc;
  logic               w_unusedLenBits;

  // The length is counted in whole beats; any sub-beat remainder is discarded
  assign w_unusedLenBits = ^x_data_send_back_length[BEAT_SHIFT-1:0];

  assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_push      = x_data_out_valid && !w_full;
  assign w_dataValid = (r_state == S_DATA) && !w_empty;
  assign w_pop       = w_dataValid && wr_data_ready;
  assign w_cmdValid  = (r_state == S_CMD);

  // Burst size is the smallest of: beats left, the burst cap, and beats to the next 4 KB page
  assign w_boundaryBytes = 13'd4096 - {1'b0, r_curAddr[11:0]};
  assign w_boundaryBeats = w_boundaryBytes >> BEAT_SHIFT;
  assign w_capRem        = (r_remBeats < REM_W'(MAX_BURST)) ? r_remBeats : REM_W'(MAX_BURST);
  assign w_capPage       = {{(REM_W-13){1'b0}}, w_boundaryBeats};
  assign w_burstCalc     = (w_capPage < w_capRem) ? w_capPage : w_capRem;

  // FIFO storage; the producer has no ready, so a write happens whenever there is room
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifoMem[r_wrPtr] <= x_data_out;
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves the count unchanged
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Back-pressure flag registered from the occupancy; the margin covers the producer's in-flight words
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_almostFull <= 1'b0;
    end else begin
      r_almostFull <= (r_count >= CNT_W'(FIFO_DEPTH - AF_MARGIN));
    end
  end

  // Sticky error flags: a word arriving into a full FIFO, and a start while a write-back is running
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_errOverflow  <= 1'b0;
      r_errStartBusy <= 1'b0;
    end else begin
      if (x_data_out_valid && w_full) begin
        r_errOverflow <= 1'b1;
      end
      if (x_data_send_back_start && (r_state != S_IDLE)) begin
        r_errStartBusy <= 1'b1;
      end
    end
  end

  // Write-back sequencer: size a burst, issue its command, stream its beats, repeat until all beats are sent
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_curAddr    <= '0;
      r_remBeats   <= '0;
      r_burstBeats <= '0;
      r_beatCnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (x_data_send_back_start) begin
            r_curAddr  <= x_data_send_back_addr;
            r_remBeats <= x_data_send_back_length[31:BEAT_SHIFT];
            if (x_data_send_back_length[31:BEAT_SHIFT] == '0) begin
              r_state <= S_DONE;
            end else begin
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_burstBeats <= w_burstCalc[BURST_W-1:0];
          r_beatCnt    <= w_burstCalc[BURST_W-1:0];
          r_state      <= S_CMD;
        end
        S_CMD: begin
          if (wr_cmd_ready) begin
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_pop) begin
            r_beatCnt <= r_beatCnt - BURST_W'(1);
            if (r_beatCnt == BURST_W'(1)) begin
              r_curAddr  <= r_curAddr + (ADDR_W'(r_burstBeats) << BEAT_SHIFT);
              r_remBeats <= r_remBeats - REM_W'(r_burstBeats);
              if (r_remBeats == REM_W'(r_burstBeats)) begin
                r_state <= S_DONE;
              end else begin
                r_state <= S_CALC;
              end
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign x_data_out_almost_full = r_almostFull;
  assign err_overflow           = r_errOverflow;
  assign err_start_busy         = r_errStartBusy;

  // Payloads are forced to zero while their valid is low so a reset leaves every output at zero
  assign wr_cmd_valid  = w_cmdValid;
  assign wr_cmd_addr   = w_cmdValid ? r_curAddr : '0;
  assign wr_cmd_len    = w_cmdValid ? 8'(r_burstBeats - BURST_W'(1)) : 8'd0;
  assign wr_data_valid = w_dataValid;
  assign wr_data       = w_dataValid ? r_fifoMem[r_rdPtr] : '0;
  assign wr_data_last  = (r_state == S_DATA) && (r_beatCnt == BURST_W'(1));
  assign busy          = (r_state != S_IDLE);
  assign done          = (r_state == S_DONE);

endmodule

// File: tb/tb_sgd_model_writeback.sv
// tb_sgd_model_writeback: drives sgd_model_writeback with random model words and
// ready patterns, and compares every cycle against a transaction-level model
// that plans bursts arithmetically and tracks buffered words in a queue.
module tb_sgd_model_writeback;

  localparam int DATA_W = 512;
  localparam int ADDR_W = 64;
  localparam int DEPTH  = 64;
  localparam int AFM    = 8;
  localparam int MAXB   = 64;

  localparam int M_IDLE = 0;
  localparam int M_CMD  = 1;
  localparam int M_DATA = 2;
  localparam int M_DONE = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              x_data_send_back_start;
  logic [ADDR_W-1:0] x_data_send_back_addr;
  logic [31:0]       x_data_send_back_length;
  logic [DATA_W-1:0] x_data_out;
  logic              x_data_out_valid;
  logic              x_data_out_almost_full;
  logic              wr_cmd_valid;
  logic              wr_cmd_ready;
  logic [ADDR_W-1:0] wr_cmd_addr;
  logic [7:0]        wr_cmd_len;
  logic [DATA_W-1:0] wr_data;
  logic              wr_data_valid;
  logic              wr_data_ready;
  logic              wr_data_last;
  logic              busy;
  logic              done;
  logic              err_overflow;
  logic              err_start_busy;

  typedef struct {
    logic [63:0] addr;
    int          beats;
  } burst_t;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] modelQ[$];
  logic [DATA_W-1:0] pushQ[$];
  burst_t            expBursts[$];
  int                phase;
  int                cmdCd;
  int                beatsLeft;
  bit                expOvf;
  bit                expStartErr;
  bit                expAf;
  int                readyMode;
  bit                ignoreAf;

  always #5 clk = ~clk;

  sgd_model_writeback #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH), .AF_MARGIN(AFM), .MAX_BURST(MAXB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .x_data_send_back_start(x_data_send_back_start),
    .x_data_send_back_addr(x_data_send_back_addr),
    .x_data_send_back_length(x_data_send_back_length),
    .x_data_out(x_data_out),
    .x_data_out_valid(x_data_out_valid),
    .x_data_out_almost_full(x_data_out_almost_full),
    .wr_cmd_valid(wr_cmd_valid),
    .wr_cmd_ready(wr_cmd_ready),
    .wr_cmd_addr(wr_cmd_addr),
    .wr_cmd_len(wr_cmd_len),
    .wr_data(wr_data),
    .wr_data_valid(wr_data_valid),
    .wr_data_ready(wr_data_ready),
    .wr_data_last(wr_data_last),
    .busy(busy),
    .done(done),
    .err_overflow(err_overflow),
    .err_start_busy(err_start_busy)
  );

  // Safety net in case the design wedges in a way the bounded loops cannot see
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] randWord();
    logic [DATA_W-1:0] w;
    for (int i = 0; i < DATA_W / 32; i++) begin
      w[i*32 +: 32] = $urandom;
    end
    return w;
  endfunction

  task automatic resetModel();
    modelQ.delete();
    pushQ.delete();
    expBursts.delete();
    phase       = M_IDLE;
    cmdCd       = 0;
    beatsLeft   = 0;
    expOvf      = 1'b0;
    expStartErr = 1'b0;
    expAf       = 1'b0;
  endtask

  // Splits a write-back into bursts: capped at MAXB beats and never crossing a 4 KB page
  task automatic planBursts(input logic [63:0] addr, input logic [31:0] len);
    logic [63:0] a;
    int          n;
    int          room;
    int          b;
    burst_t      bt;
    expBursts.delete();
    a = addr;
    n = int'(len / 64);
    while (n > 0) begin
      room = int'((64'd4096 - (a % 64'd4096)) / 64'd64);
      b = n;
      if (b > MAXB) b = MAXB;
      if (b > room) b = room;
      bt.addr  = a;
      bt.beats = b;
      expBursts.push_back(bt);
      a = a + 64'(b * 64);
      n = n - b;
    end
  endtask

  task automatic applyStimulus(input bit start, input logic [63:0] addr, input logic [31:0] len);
    x_data_send_back_start  = start;
    x_data_send_back_addr   = addr;
    x_data_send_back_length = len;
    if (pushQ.size() > 0 && (ignoreAf || !x_data_out_almost_full)) begin
      x_data_out       = pushQ.pop_front();
      x_data_out_valid = 1'b1;
    end else begin
      x_data_out       = randWord();
      x_data_out_valid = 1'b0;
    end
    if (readyMode == 0) begin
      wr_cmd_ready  = 1'b1;
      wr_data_ready = 1'b1;
    end else begin
      wr_cmd_ready  = ($urandom_range(0, 1) == 1);
      wr_data_ready = ($urandom_range(0, 3) == 0);
    end
  endtask

  // Compares this cycle's outputs with the model, then advances the model across the coming edge
  task automatic stepCycle();
    bit eCmd, eData, eDone, hsC, hsD;
    int sizeStart;
    int phaseStart;
    if (!rst_n) begin
      resetModel();
      @(negedge clk);
      return;
    end
    sizeStart  = modelQ.size();
    phaseStart = phase;
    eCmd  = (phase == M_CMD) && (cmdCd == 0);
    eData = (phase == M_DATA) && (sizeStart > 0);
    eDone = (phase == M_DONE);
    checkOutput("busy", busy, phase != M_IDLE);
    checkOutput("cmd_valid", wr_cmd_valid, eCmd);
    checkOutput("data_valid", wr_data_valid, eData);
    checkOutput("done", done, eDone);
    checkOutput("almost_full", x_data_out_almost_full, expAf);
    checkOutput("err_overflow", err_overflow, expOvf);
    checkOutput("err_start_busy", err_start_busy, expStartErr);
    if (eCmd) begin
      checkOutput("cmd_addr", wr_cmd_addr, expBursts[0].addr);
      checkOutput("cmd_len", wr_cmd_len, expBursts[0].beats - 1);
    end
    if (eData) begin
      checkOutput("data", wr_data, modelQ[0]);
      checkOutput("data_last", wr_data_last, beatsLeft == 1);
    end
    hsC = eCmd && wr_cmd_ready;
    hsD = eData && wr_data_ready;
    case (phase)
      M_IDLE: begin
        if (x_data_send_back_start) begin
          planBursts(x_data_send_back_addr, x_data_send_back_length);
          if (expBursts.size() == 0) begin
            phase = M_DONE;
          end else begin
            phase = M_CMD;
            cmdCd = 1;
          end
        end
      end
      M_CMD: begin
        if (cmdCd > 0) begin
          cmdCd--;
        end else if (hsC) begin
          phase     = M_DATA;
          beatsLeft = expBursts[0].beats;
        end
      end
      M_DATA: begin
        if (hsD) begin
          void'(modelQ.pop_front());
          beatsLeft--;
          if (beatsLeft == 0) begin
            void'(expBursts.pop_front());
            if (expBursts.size() > 0) begin
              phase = M_CMD;
              cmdCd = 1;
            end else begin
              phase = M_DONE;
            end
          end
        end
      end
      default: begin
        phase = M_IDLE;
      end
    endcase
    if (x_data_send_back_start && phaseStart != M_IDLE) begin
      expStartErr = 1'b1;
    end
    if (x_data_out_valid) begin
      if (sizeStart < DEPTH) modelQ.push_back(x_data_out);
      else expOvf = 1'b1;
    end
    expAf = (sizeStart >= DEPTH - AFM);
    @(negedge clk);
  endtask

  task automatic runStart(input logic [63:0] addr, input logic [31:0] len);
    applyStimulus(1'b1, addr, len);
    stepCycle();
  endtask

  task automatic runCycles(input int n);
    repeat (n) begin
      applyStimulus(1'b0, '0, '0);
      stepCycle();
    end
  endtask

  task automatic runUntilIdle(input string tag, input int maxCycles);
    int c;
    c = 0;
    while ((phase != M_IDLE || pushQ.size() > 0) && c < maxCycles) begin
      applyStimulus(1'b0, '0, '0);
      stepCycle();
      c++;
    end
    checkOutput(tag, c < maxCycles, 1'b1);
  endtask

  task automatic queueWords(input int n);
    repeat (n) pushQ.push_back(randWord());
  endtask

  initial begin
    int c;
    rst_n     = 1'b0;
    readyMode = 0;
    ignoreAf  = 1'b0;
    resetModel();
    applyStimulus(1'b0, '0, '0);
    @(negedge clk);
    repeat (3) begin
      applyStimulus(1'b0, '0, '0);
      stepCycle();
    end
    rst_n = 1'b1;

    $display("[TB] reset state");
    checkOutput("rst_cmd_valid", wr_cmd_valid, 1'b0);
    checkOutput("rst_cmd_addr", wr_cmd_addr, '0);
    checkOutput("rst_cmd_len", wr_cmd_len, '0);
    checkOutput("rst_data", wr_data, '0);
    checkOutput("rst_data_valid", wr_data_valid, 1'b0);
    checkOutput("rst_data_last", wr_data_last, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_af", x_data_out_almost_full, 1'b0);

    $display("[TB] single burst, back-to-back words, ready high");
    queueWords(16);
    runStart(64'h4000_0000, 32'd1024);
    runUntilIdle("t1_timeout", 200);

    $display("[TB] 4 KB boundary split with random ready");
    readyMode = 1;
    queueWords(8);
    runStart(64'h4000_0F80, 32'd512);
    runUntilIdle("t2_timeout", 500);

    $display("[TB] two max-size bursts");
    readyMode = 0;
    queueWords(128);
    runStart(64'h0, 32'd8192);
    runUntilIdle("t3_timeout", 1000);

    $display("[TB] slow drain with producer honouring almost_full");
    readyMode = 1;
    queueWords(70);
    runStart(64'h2000, 32'd4480);
    runUntilIdle("t4_timeout", 3000);

    $display("[TB] overflow by pushing into a full FIFO");
    readyMode = 0;
    ignoreAf  = 1'b1;
    queueWords(65);
    runUntilIdle("t5_fill_timeout", 200);
    ignoreAf  = 1'b0;
    runCycles(2);
    checkOutput("ovf_sticky", err_overflow, 1'b1);
    runStart(64'h3000, 32'd4096);
    runUntilIdle("t5_drain_timeout", 500);

    $display("[TB] zero length and start while busy");
    runStart(64'h100, 32'd0);
    runCycles(3);
    queueWords(4);
    runStart(64'h5000, 32'd256);
    runCycles(2);
    runStart(64'h9000, 32'd640);
    runUntilIdle("t6_timeout", 200);
    checkOutput("start_busy_sticky", err_start_busy, 1'b1);

    $display("[TB] leftover words kept for the next write-back");
    queueWords(6);
    runStart(64'h6000, 32'd256);
    runUntilIdle("t7a_timeout", 200);
    runStart(64'h7000, 32'd128);
    runUntilIdle("t7b_timeout", 200);

    $display("[TB] reset in the middle of a burst");
    readyMode = 1;
    queueWords(10);
    runStart(64'h8000, 32'd640);
    c = 0;
    while (!(phase == M_DATA && beatsLeft <= 7) && c < 400) begin
      applyStimulus(1'b0, '0, '0);
      stepCycle();
      c++;
    end
    checkOutput("reach_data_timeout", c < 400, 1'b1);
    rst_n = 1'b0;
    applyStimulus(1'b0, '0, '0);
    stepCycle();
    rst_n = 1'b1;
    checkOutput("midrst_cmd_valid", wr_cmd_valid, 1'b0);
    checkOutput("midrst_data_valid", wr_data_valid, 1'b0);
    checkOutput("midrst_busy", busy, 1'b0);
    checkOutput("midrst_err_start", err_start_busy, 1'b0);
    runCycles(4);
    queueWords(4);
    runStart(64'h9000, 32'd256);
    runUntilIdle("t8_timeout", 300);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
